// File: rtl/vend_pkg.sv
// Shared coin codes, coin values and controller state encoding for the vending controller.
package vend_pkg;

  localparam logic [1:0] COIN_N = 2'b00;
  localparam logic [1:0] COIN_D = 2'b01;
  localparam logic [1:0] COIN_Q = 2'b10;
  localparam logic [1:0] COIN_X = 2'b11;

  localparam int VAL_N = 5;
  localparam int VAL_D = 10;
  localparam int VAL_Q = 25;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_VEND_ON  = 3'd1,
    ST_VEND_GAP = 3'd2,
    ST_CHG_ON   = 3'd3,
    ST_CHG_GAP  = 3'd4
  } state_e;

  // Invalid codes are worth nothing so they never disturb the credit.
  function automatic int coin_value(input logic [1:0] sel);
    case (sel)
      COIN_N:  coin_value = VAL_N;
      COIN_D:  coin_value = VAL_D;
      COIN_Q:  coin_value = VAL_Q;
      default: coin_value = 0;
    endcase
  endfunction

endpackage

// File: rtl/vend_pulse_timer.sv
// Loadable down-counter timing the ON and GAP phases; done is high once the count reaches zero.
module vend_pulse_timer #(
  parameter int PULSE_CYC = 2,
  parameter int TW        = $clog2(PULSE_CYC + 1)
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic load_i,
  output logic done_o
);

  localparam logic [TW-1:0] LOAD_VAL = TW'(PULSE_CYC - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Counter register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Load takes priority; otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: coin credit, vend pulse, greedy change/refund pulses, error and ready flags.
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter int PRICE     = 30,
  parameter int PULSE_CYC = 2,
  parameter int CREDIT_W  = 7
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                COIN_VALID,
  input  logic [1:0]          COIN_SEL,
  input  logic                CANCEL,
  output logic                RDY,
  output logic                LD0,
  output logic                LD1,
  output logic                LD2,
  output logic                LD3,
  output logic                ERR,
  output logic [CREDIT_W-1:0] CREDIT
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] N_C     = CREDIT_W'(VAL_N);
  localparam logic [CREDIT_W-1:0] D_C     = CREDIT_W'(VAL_D);
  localparam logic [CREDIT_W-1:0] Q_C     = CREDIT_W'(VAL_Q);

  state_e               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [3:0]           ld_q, ld_d;  // {LD3, LD2, LD1, LD0}
  logic                 err_q, err_d;
  logic                 rdy_q, rdy_d;

  logic                 coin_ok_s;
  logic [CREDIT_W-1:0]  coin_add_s;
  logic [CREDIT_W-1:0]  sum_s;
  logic [CREDIT_W-1:0]  chg_src_s;
  logic [CREDIT_W-1:0]  chg_rem_s;
  logic [3:0]           chg_ld_s;
  logic                 tmr_load_s;
  logic                 tmr_done_s;

  vend_pulse_timer #(.PULSE_CYC(PULSE_CYC)) u_timer (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .load_i (tmr_load_s),
    .done_o (tmr_done_s)
  );

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      ld_q     <= 4'b0000;
      err_q    <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      ld_q     <= ld_d;
      err_q    <= err_d;
      rdy_q    <= rdy_d;
    end
  end

  // Next-state, credit bookkeeping and greedy coin choice.
  always_comb begin
    coin_ok_s  = COIN_VALID && (COIN_SEL != COIN_X);
    coin_add_s = coin_ok_s ? CREDIT_W'(coin_value(COIN_SEL)) : '0;
    sum_s      = credit_q + coin_add_s;
    // In IDLE a refund pays out the coin arriving this cycle as well.
    chg_src_s  = (state_q == ST_IDLE) ? sum_s : credit_q;
    if (chg_src_s >= Q_C) begin
      chg_ld_s  = 4'b1000;
      chg_rem_s = chg_src_s - Q_C;
    end else if (chg_src_s >= D_C) begin
      chg_ld_s  = 4'b0010;
      chg_rem_s = chg_src_s - D_C;
    end else begin
      chg_ld_s  = 4'b0100;
      chg_rem_s = chg_src_s - N_C;
    end

    state_d    = state_q;
    credit_d   = credit_q;
    ld_d       = ld_q;
    err_d      = 1'b0;
    tmr_load_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ld_d  = 4'b0000;
        err_d = COIN_VALID && (COIN_SEL == COIN_X);
        if (CANCEL && (sum_s != '0)) begin
          state_d    = ST_CHG_ON;
          credit_d   = chg_rem_s;
          ld_d       = chg_ld_s;
          tmr_load_s = 1'b1;
        end else if (sum_s >= PRICE_C) begin
          state_d    = ST_VEND_ON;
          credit_d   = sum_s - PRICE_C;
          ld_d       = 4'b0001;
          tmr_load_s = 1'b1;
        end else begin
          credit_d = sum_s;
        end
      end
      ST_VEND_ON, ST_CHG_ON: begin
        if (tmr_done_s) begin
          state_d    = (state_q == ST_VEND_ON) ? ST_VEND_GAP : ST_CHG_GAP;
          ld_d       = 4'b0000;
          tmr_load_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_VEND_GAP, ST_CHG_GAP: begin
        if (tmr_done_s && (credit_q != '0)) begin
          state_d    = ST_CHG_ON;
          credit_d   = chg_rem_s;
          ld_d       = chg_ld_s;
          tmr_load_s = 1'b1;
        end else if (tmr_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
        ld_d     = 4'b0000;
      end
    endcase

    rdy_d = (state_d == ST_IDLE);
  end

  assign RDY    = rdy_q;
  assign LD0    = ld_q[0];
  assign LD1    = ld_q[1];
  assign LD2    = ld_q[2];
  assign LD3    = ld_q[3];
  assign ERR    = err_q;
  assign CREDIT = credit_q;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Self-checking bench for vend_ctrl_param: directed vector table, reset corner case, random run against a schedule model.
module tb_vend_ctrl_param;

  localparam int PRICE = 30;
  localparam int P     = 2;
  localparam int CW    = 7;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          COIN_VALID = 1'b0;
  logic [1:0]    COIN_SEL = 2'b00;
  logic          CANCEL = 1'b0;
  logic          RDY, LD0, LD1, LD2, LD3, ERR;
  logic [CW-1:0] CREDIT;

  int n_cmp  = 0;
  int n_fail = 0;

  vend_ctrl_param #(.PRICE(PRICE), .PULSE_CYC(P), .CREDIT_W(CW)) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .COIN_VALID (COIN_VALID),
    .COIN_SEL   (COIN_SEL),
    .CANCEL     (CANCEL),
    .RDY        (RDY),
    .LD0        (LD0),
    .LD1        (LD1),
    .LD2        (LD2),
    .LD3        (LD3),
    .ERR        (ERR),
    .CREDIT     (CREDIT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit       cv;
    bit [1:0] sel;
    bit       can;
    bit [3:0] ld;
    int       cr;
    bit       rdy;
    bit       err;
  } vec_t;

  typedef struct {
    bit [3:0] ld;
    int       cr;
    bit       rdy;
  } exp_t;

  vec_t vecs[$];

  task automatic v(input bit cv, input bit [1:0] sel, input bit can,
                   input bit [3:0] ld, input int cr, input bit rdy, input bit err);
    vec_t r;
    r.cv = cv; r.sel = sel; r.can = can; r.ld = ld; r.cr = cr; r.rdy = rdy; r.err = err;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input bit [3:0] ld, input int cr, input bit rdy, input bit err);
    n_cmp++;
    if ({LD3, LD2, LD1, LD0} !== ld || int'(CREDIT) != cr || RDY !== rdy || ERR !== err) begin
      n_fail++;
      $display("FAIL %s: got ld=%b credit=%0d rdy=%b err=%b, expected ld=%b credit=%0d rdy=%b err=%b",
               name, {LD3, LD2, LD1, LD0}, CREDIT, RDY, ERR, ld, cr, rdy, err);
    end
  endtask

  task automatic cyc(input bit cv, input bit [1:0] sel, input bit can);
    @(negedge CLK);
    COIN_VALID = cv;
    COIN_SEL   = sel;
    CANCEL     = can;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    COIN_VALID = 1'b0; CANCEL = 1'b0; COIN_SEL = 2'b00;
    RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
  endtask

  // Reference model: a transaction schedule of expected per-cycle outputs.
  exp_t mq[$];
  int   m_credit;
  bit   m_rdy;

  task automatic push_phase(input bit [3:0] ld, input int cr);
    exp_t e;
    for (int i = 0; i < P; i++) begin
      e.ld = ld; e.cr = cr; e.rdy = 1'b0; mq.push_back(e);
    end
    for (int i = 0; i < P; i++) begin
      e.ld = 4'b0000; e.cr = cr; e.rdy = 1'b0; mq.push_back(e);
    end
  endtask

  task automatic plan(input int amount, input bit vend);
    int amt;
    amt = amount;
    if (vend) begin
      amt = amt - PRICE;
      push_phase(4'b0001, amt);
    end
    while (amt > 0) begin
      if (amt >= 25) begin amt -= 25; push_phase(4'b1000, amt); end
      else if (amt >= 10) begin amt -= 10; push_phase(4'b0010, amt); end
      else begin amt -= 5; push_phase(4'b0100, amt); end
    end
    m_credit = 0;
  endtask

  task automatic model_step(input bit cv, input bit [1:0] sel, input bit can,
                            output exp_t e, output bit err);
    int val, sum;
    err = 1'b0;
    if (m_rdy) begin
      val = (sel == 2'd0) ? 5 : (sel == 2'd1) ? 10 : (sel == 2'd2) ? 25 : 0;
      err = cv && (sel == 2'd3);
      sum = m_credit + (cv ? val : 0);
      if (can && sum > 0) plan(sum, 1'b0);
      else if (sum >= PRICE) plan(sum, 1'b1);
      else m_credit = sum;
    end
    if (mq.size() > 0) begin
      e = mq.pop_front();
    end else begin
      e.ld = 4'b0000; e.cr = m_credit; e.rdy = 1'b1;
    end
    m_rdy = e.rdy;
  endtask

  initial begin
    exp_t e;
    bit   eerr;
    bit   seen;
    bit   cv, can;
    bit [1:0] sel;

    // Nickels x6: credit climbs, sixth coin vends with no change.
    for (int i = 1; i <= 5; i++) v(1, 0, 0, 4'b0000, 5 * i, 1, 0);
    v(1, 0, 0, 4'b0001, 0, 0, 0); v(0, 0, 0, 4'b0001, 0, 0, 0);
    v(0, 0, 0, 4'b0000, 0, 0, 0); v(0, 0, 0, 4'b0000, 0, 0, 0);
    v(0, 0, 0, 4'b0000, 0, 1, 0);
    // Dime + quarter: vend then nickel change.
    v(1, 1, 0, 4'b0000, 10, 1, 0);
    v(1, 2, 0, 4'b0001, 5, 0, 0); v(0, 0, 0, 4'b0001, 5, 0, 0);
    v(0, 0, 0, 4'b0000, 5, 0, 0); v(0, 0, 0, 4'b0000, 5, 0, 0);
    v(0, 0, 0, 4'b0100, 0, 0, 0); v(0, 0, 0, 4'b0100, 0, 0, 0);
    v(0, 0, 0, 4'b0000, 0, 0, 0); v(0, 0, 0, 4'b0000, 0, 0, 0);
    v(0, 0, 0, 4'b0000, 0, 1, 0);
    // Dime, then quarter with cancel: refund 35 as quarter + dime, no vend.
    v(1, 1, 0, 4'b0000, 10, 1, 0);
    v(1, 2, 1, 4'b1000, 10, 0, 0); v(0, 0, 0, 4'b1000, 10, 0, 0);
    v(0, 0, 0, 4'b0000, 10, 0, 0); v(0, 0, 0, 4'b0000, 10, 0, 0);
    v(0, 0, 0, 4'b0010, 0, 0, 0); v(0, 0, 0, 4'b0010, 0, 0, 0);
    v(0, 0, 0, 4'b0000, 0, 0, 0); v(0, 0, 0, 4'b0000, 0, 0, 0);
    v(0, 0, 0, 4'b0000, 0, 1, 0);
    // Invalid code, then strobes/cancel/invalid ignored while busy.
    v(1, 1, 0, 4'b0000, 10, 1, 0);
    v(1, 3, 0, 4'b0000, 10, 1, 1); v(0, 0, 0, 4'b0000, 10, 1, 0);
    v(1, 2, 0, 4'b0001, 5, 0, 0); v(1, 1, 0, 4'b0001, 5, 0, 0);
    v(1, 2, 0, 4'b0000, 5, 0, 0); v(0, 0, 1, 4'b0000, 5, 0, 0);
    v(0, 0, 0, 4'b0100, 0, 0, 0); v(1, 3, 0, 4'b0100, 0, 0, 0);
    v(0, 0, 0, 4'b0000, 0, 0, 0); v(0, 0, 0, 4'b0000, 0, 0, 0);
    v(0, 0, 0, 4'b0000, 0, 1, 0);
    // Cancel with zero credit is ignored.
    v(0, 0, 1, 4'b0000, 0, 1, 0);
    // Two quarters: vend, then two dimes with credit 20, 10, 0.
    v(1, 2, 0, 4'b0000, 25, 1, 0);
    v(1, 2, 0, 4'b0001, 20, 0, 0); v(0, 0, 0, 4'b0001, 20, 0, 0);
    v(0, 0, 0, 4'b0000, 20, 0, 0); v(0, 0, 0, 4'b0000, 20, 0, 0);
    v(0, 0, 0, 4'b0010, 10, 0, 0); v(0, 0, 0, 4'b0010, 10, 0, 0);
    v(0, 0, 0, 4'b0000, 10, 0, 0); v(0, 0, 0, 4'b0000, 10, 0, 0);
    v(0, 0, 0, 4'b0010, 0, 0, 0); v(0, 0, 0, 4'b0010, 0, 0, 0);
    v(0, 0, 0, 4'b0000, 0, 0, 0); v(0, 0, 0, 4'b0000, 0, 0, 0);
    v(0, 0, 0, 4'b0000, 0, 1, 0);

    do_reset();
    #1;
    chk("reset_state", 4'b0000, 0, 1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].cv, vecs[i].sel, vecs[i].can);
      chk($sformatf("vec%0d", i), vecs[i].ld, vecs[i].cr, vecs[i].rdy, vecs[i].err);
    end

    // Asynchronous reset during the first change pulse.
    do_reset();
    cyc(1, 2, 0);
    cyc(1, 2, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(0, 0, 0);
      seen = (LD1 === 1'b1);
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rst_wait_ld1: got LD1=%b after 20 cycles, expected 1", LD1);
    end
    #2;
    RSTN = 1'b0;
    #1;
    chk("rst_async", 4'b0000, 0, 1'b1, 1'b0);
    @(negedge CLK);
    RSTN = 1'b1;
    cyc(0, 0, 0);
    chk("rst_release", 4'b0000, 0, 1'b1, 1'b0);
    cyc(1, 0, 0);
    chk("rst_after_coin", 4'b0000, 5, 1'b1, 1'b0);

    // Random traffic against the schedule model.
    do_reset();
    m_credit = 0;
    m_rdy    = 1'b1;
    mq.delete();
    for (int i = 0; i < 3000; i++) begin
      cv  = ($urandom_range(0, 9) < 4);
      sel = 2'($urandom_range(0, 3));
      can = ($urandom_range(0, 19) == 0);
      cyc(cv, sel, can);
      model_step(cv, sel, can, e, eerr);
      chk($sformatf("rand%0d", i), e.ld, e.cr, e.rdy, eerr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
